// File: rtl/clock_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// clock_pkg: shared calendar constants, week encoding and BCD/date helpers. Rev 1.0
// ---------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [3:0] {
    WK_SUN = 4'd0,
    WK_MON = 4'd1,
    WK_TUE = 4'd2,
    WK_WED = 4'd3,
    WK_THU = 4'd4,
    WK_FRI = 4'd5,
    WK_SAT = 4'd6
  } week_e;

  localparam logic [15:0] c_rst_year  = 16'h2000;
  localparam logic [7:0]  c_rst_month = 8'h01;
  localparam logic [7:0]  c_rst_day   = 8'h01;
  localparam logic [3:0]  c_rst_week  = 4'(WK_SAT);

  function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
    return (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [15:0] bcd_inc4(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic nib_ok8(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Two BCD digits divisible by 4: even tens need 0/4/8 units, odd tens need 2/6.
  function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
    return t[0] ? (o == 4'd2 || o == 4'd6) : (o == 4'd0 || o == 4'd4 || o == 4'd8);
  endfunction

  function automatic logic is_leap(input logic [15:0] y);
    return (y[7:0] == 8'h00) ? div4(y[15:12], y[11:8]) : div4(y[7:4], y[3:0]);
  endfunction

  function automatic logic [7:0] month_max(input logic [7:0] m, input logic leap);
    case (m)
      8'h02:                      return leap ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
      default:                    return 8'h31;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_counter: two-digit BCD counter 00..MAX with enable, carry and sync load. Rev 1.0
// ---------------------------------------------------------------------------
module bcd_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  output logic [7:0] o_val,
  output logic       o_carry
);

  localparam logic [7:0] c_max_bcd = {4'(MAX / 10), 4'(MAX % 10)};

  logic [7:0] r_val;

  assign o_carry = i_en && (r_val == c_max_bcd);
  assign o_val   = r_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_val <= 8'h00;
    end else if (i_load) begin
      r_val <= i_load_val;
    end else if (i_en) begin
      r_val <= o_carry ? 8'h00 : bcd_inc2(r_val);
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_keeper.sv
`default_nettype none
// ---------------------------------------------------------------------------
// time_keeper: BCD calendar clock with second prescaler, pause and validated load. Rev 1.0
// ---------------------------------------------------------------------------
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pause,
  input  logic        load,
  input  logic [15:0] load_year,
  input  logic [7:0]  load_month,
  input  logic [7:0]  load_day,
  input  logic [7:0]  load_hour,
  input  logic [7:0]  load_minute,
  input  logic [7:0]  load_sec,
  input  logic [3:0]  load_week,
  output logic [15:0] year,
  output logic [7:0]  month,
  output logic [7:0]  day,
  output logic [7:0]  hour,
  output logic [7:0]  minute,
  output logic [7:0]  sec,
  output logic [3:0]  week,
  output logic        sec_pulse,
  output logic        load_err
);

  localparam int c_presc_w = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(CLK_HZ - 1);

  logic [c_presc_w-1:0] r_presc;
  logic [15:0] r_year;
  logic [7:0]  r_month;
  logic [7:0]  r_day;
  logic [3:0]  r_week;
  logic        r_sec_pulse;
  logic        r_load_err;

  logic w_adv, w_ld_valid, w_ld_take;
  logic w_sec_carry, w_min_carry, w_day_inc;
  logic w_leap, w_day_wrap, w_month_wrap;
  logic [7:0] w_mmax;

  // Any load, accepted or rejected, suppresses the second advance in its cycle.
  assign w_adv = !load && !pause && (r_presc == c_presc_max);

  assign w_ld_valid = nib_ok8(load_year[15:8]) && nib_ok8(load_year[7:0]) &&
                      nib_ok8(load_month) && nib_ok8(load_day) &&
                      nib_ok8(load_hour) && nib_ok8(load_minute) && nib_ok8(load_sec) &&
                      (load_month >= 8'h01) && (load_month <= 8'h12) &&
                      (load_day >= 8'h01) &&
                      (load_day <= month_max(load_month, is_leap(load_year))) &&
                      (load_hour <= 8'h23) && (load_minute <= 8'h59) &&
                      (load_sec <= 8'h59) && (load_week <= 4'd6);
  assign w_ld_take  = load && w_ld_valid;

  assign w_leap       = is_leap(r_year);
  assign w_mmax       = month_max(r_month, w_leap);
  assign w_day_wrap   = w_day_inc && (r_day == w_mmax);
  assign w_month_wrap = w_day_wrap && (r_month == 8'h12);

  bcd_counter #(.MAX(59)) u_sec (
    .clk(clk), .rst(rst), .i_en(w_adv), .i_load(w_ld_take), .i_load_val(load_sec),
    .o_val(sec), .o_carry(w_sec_carry)
  );

  bcd_counter #(.MAX(59)) u_min (
    .clk(clk), .rst(rst), .i_en(w_sec_carry), .i_load(w_ld_take), .i_load_val(load_minute),
    .o_val(minute), .o_carry(w_min_carry)
  );

  bcd_counter #(.MAX(23)) u_hour (
    .clk(clk), .rst(rst), .i_en(w_min_carry), .i_load(w_ld_take), .i_load_val(load_hour),
    .o_val(hour), .o_carry(w_day_inc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_year      <= c_rst_year;
      r_month     <= c_rst_month;
      r_day       <= c_rst_day;
      r_week      <= c_rst_week;
      r_sec_pulse <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_sec_pulse <= w_adv;
      r_load_err  <= load && !w_ld_valid;
      if (load) begin
        if (w_ld_valid) begin
          r_presc <= '0;
          r_year  <= load_year;
          r_month <= load_month;
          r_day   <= load_day;
          r_week  <= load_week;
        end
      end else begin
        if (!pause) begin
          r_presc <= w_adv ? '0 : r_presc + 1'b1;
        end
        if (w_day_inc) begin
          r_day  <= w_day_wrap ? 8'h01 : bcd_inc2(r_day);
          r_week <= (r_week == 4'(WK_SAT)) ? 4'(WK_SUN) : r_week + 4'd1;
        end
        if (w_day_wrap) begin
          r_month <= w_month_wrap ? 8'h01 : bcd_inc2(r_month);
        end
        if (w_month_wrap) begin
          r_year <= bcd_inc4(r_year);
        end
      end
    end
  end

  assign year      = r_year;
  assign month     = r_month;
  assign day       = r_day;
  assign week      = r_week;
  assign sec_pulse = r_sec_pulse;
  assign load_err  = r_load_err;

endmodule
`default_nettype wire
